output_buffer_receiver: RTL and testbench
=========================================

Name: output_buffer_receiver

Overview:
Receive-side counterpart of the sensor output buffer. Samples the bus beats the sensor streams out (OUTPUT_BUS_WIDTH pixels per beat, qualified by a valid strobe) and reassembles them into full pixel rows. Delivers each completed row with its row index over a valid/ready handshake, and flags end of frame. Sits in the readout/test-harness side of the design, in the same clock domain as the sensor's output clock.

Parameters:
PIXEL_ARRAY_WIDTH, 8, pixels per row; must be an integer multiple of OUTPUT_BUS_WIDTH
PIXEL_ARRAY_HEIGHT, 8, rows per frame; must be >= 2
OUTPUT_BUS_WIDTH, 2, pixels per bus beat
PIXEL_BITS, 8, bits per pixel, already binary-decoded
(derived) BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; BEAT_BITS = max(1, clog2(BEATS)); ROW_BITS = max(1, clog2(PIXEL_ARRAY_HEIGHT))

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous reset, active-high
BUS_VALID  in  1  high while the transmitter drives a valid beat on BUS_DATA
BUS_DATA  in  OUTPUT_BUS_WIDTH*PIXEL_BITS  beat; pixel j of the beat is at [(j+1)*PIXEL_BITS-1 : j*PIXEL_BITS]
ROW_DATA  out  PIXEL_ARRAY_WIDTH*PIXEL_BITS  assembled row; pixel i is at [(i+1)*PIXEL_BITS-1 : i*PIXEL_BITS]
ROW_VALID  out  1  ROW_DATA and ROW_INDEX hold a row
ROW_READY  in  1  consumer accepts the row when ROW_VALID & ROW_READY
ROW_INDEX  out  ROW_BITS  row number within the frame, 0..PIXEL_ARRAY_HEIGHT-1
FRAME_DONE  out  1  one-cycle pulse on acceptance of row PIXEL_ARRAY_HEIGHT-1
ERR_SHORT  out  1  sticky: a burst ended before BEATS beats were received
ERR_OVERFLOW  out  1  sticky: a completed row was dropped because the output slot was full
ERR_CLEAR  in  1  clears both sticky error flags

Behaviour:
- Reset: synchronous with RESET. Sets beat_cnt=0, row_cnt=0, assembly register=0, ROW_DATA=0, ROW_VALID=0, ROW_INDEX=0, FRAME_DONE=0, ERR_SHORT=0, ERR_OVERFLOW=0. Reset mid-burst or with a pending row discards everything, with no error raised.
- Beat ordering: beat k of a burst fills pixels k*OUTPUT_BUS_WIDTH .. k*OUTPUT_BUS_WIDTH+OUTPUT_BUS_WIDTH-1, with beat 0 holding pixels 0 and up.
- Assembly: on each cycle with BUS_VALID=1, write BUS_DATA into slot beat_cnt of the assembly register.
  - If beat_cnt<BEATS-1, increment beat_cnt.
  - If beat_cnt=BEATS-1, the row is complete: beat_cnt wraps to 0.
- Back-to-back rows: if BUS_VALID stays high after row completion, the next beat is beat 0 of the next row. No idle cycle is required between rows.
- Short burst: if BUS_VALID=0 while beat_cnt!=0:
  - set ERR_SHORT;
  - reset beat_cnt to 0 and discard the partial row;
  - leave row_cnt unchanged.
  BUS_VALID=0 with beat_cnt=0 is idle.
- Output slot (single entry):
  - Slot is free when ROW_VALID=0, or when ROW_VALID & ROW_READY in the same cycle.
  - On row completion with the slot free: next cycle, ROW_DATA = assembled row, with the final beat included (bypass the last beat directly, do not wait a cycle). Also ROW_INDEX=row_cnt and ROW_VALID=1.
  - Latency is 1 cycle from the last beat to ROW_VALID.
  - On row completion with the slot not free: drop the row and set ERR_OVERFLOW. The held row is unchanged.
  - ROW_VALID=1 and ROW_READY=0 with no new completion: hold ROW_DATA and ROW_INDEX stable.
  - ROW_VALID & ROW_READY with no new completion: ROW_VALID=0 next cycle. ROW_DATA keeps its last value.
- Row counter: row_cnt advances on every row completion, whether delivered or dropped. It wraps from PIXEL_ARRAY_HEIGHT-1 to 0.
- FRAME_DONE: registered, high for exactly one cycle, in the cycle after ROW_VALID & ROW_READY & ROW_INDEX=PIXEL_ARRAY_HEIGHT-1.
- Errors: sticky until ERR_CLEAR. If ERR_CLEAR coincides with a new error event, the flag is 1 next cycle (the set wins).
- Only CLK is used. No combinational path from BUS_* to any output. ROW_READY reaches outputs only through registers.

Test Plan:
- Defaults (BEATS=4): reset, then 4 consecutive beats 0x0100, 0x0302, 0x0504, 0x0706 with ROW_READY=1 -> 1 cycle after beat 4: ROW_VALID=1, ROW_DATA=0x0706050403020100, ROW_INDEX=0; ROW_VALID=0 on the following cycle.
- 8 back-to-back rows, 32 beats with BUS_VALID held high, ROW_READY=1 -> ROW_INDEX 0..7 in order, 4 cycles apart; FRAME_DONE pulses once, 1 cycle after row 7 is accepted; a 9th row gets ROW_INDEX=0.
- Burst of 2 beats, then BUS_VALID=0 -> ERR_SHORT=1, no ROW_VALID, row_cnt still 0. Next full row arrives with ROW_INDEX=0. ERR_CLEAR pulse -> ERR_SHORT=0.
- ROW_READY=0 while two rows complete back-to-back -> first row held stable, ERR_OVERFLOW=1, second row dropped. When ROW_READY is raised the first row is accepted; the next completed row gets ROW_INDEX=2.
- Acceptance (ROW_VALID & ROW_READY) in the same cycle the next row completes -> no overflow; ROW_VALID stays 1 and ROW_INDEX advances by 1.
- RESET asserted after beat 2 of a row with a row pending -> next cycle all outputs 0, no error flags; a fresh 4-beat row afterwards yields ROW_INDEX=0.

Source files
------------

// File: rtl/output_buffer_receiver_if.sv
// Bus/row interface for output_buffer_receiver.
//   master : transmitter + row consumer side (drives beats, ROW_READY, ERR_CLEAR)
//   slave  : the receiver (drives assembled rows, frame pulse, sticky errors)
// Signals:
//   BUS_VALID/BUS_DATA      incoming beats, OUTPUT_BUS_WIDTH pixels each
//   ROW_DATA/ROW_VALID/
//   ROW_READY/ROW_INDEX     assembled row handshake
//   FRAME_DONE              pulse after the last row of a frame is accepted
//   ERR_SHORT/ERR_OVERFLOW  sticky errors, ERR_CLEAR clears them
interface output_buffer_receiver_if #(
   parameter int PIXEL_ARRAY_WIDTH  = 8,
   parameter int PIXEL_ARRAY_HEIGHT = 8,
   parameter int OUTPUT_BUS_WIDTH   = 2,
   parameter int PIXEL_BITS         = 8
);
   localparam int ROW_BITS = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

   logic                                      BUS_VALID;
   logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]    BUS_DATA;
   logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   ROW_DATA;
   logic                                      ROW_VALID;
   logic                                      ROW_READY;
   logic [ROW_BITS-1:0]                       ROW_INDEX;
   logic                                      FRAME_DONE;
   logic                                      ERR_SHORT;
   logic                                      ERR_OVERFLOW;
   logic                                      ERR_CLEAR;

   modport master (
      output BUS_VALID, BUS_DATA, ROW_READY, ERR_CLEAR,
      input  ROW_DATA, ROW_VALID, ROW_INDEX, FRAME_DONE, ERR_SHORT, ERR_OVERFLOW
   );

   modport slave (
      input  BUS_VALID, BUS_DATA, ROW_READY, ERR_CLEAR,
      output ROW_DATA, ROW_VALID, ROW_INDEX, FRAME_DONE, ERR_SHORT, ERR_OVERFLOW
   );
endinterface

// File: rtl/output_buffer_receiver.sv
// Receive side of the sensor output buffer: reassembles bus beats into pixel
// rows and hands each row out through a single-entry valid/ready slot.
// Ports:
//   CLK    rising-edge clock (sensor output clock domain)
//   RESET  synchronous, active-high
//   bus    output_buffer_receiver_if.slave (beats in, rows/flags out)
// All outputs come straight from flops; BUS_* and ROW_READY only steer the
// next-state logic.
module output_buffer_receiver #(
   parameter int PIXEL_ARRAY_WIDTH  = 8,
   parameter int PIXEL_ARRAY_HEIGHT = 8,
   parameter int OUTPUT_BUS_WIDTH   = 2,
   parameter int PIXEL_BITS         = 8
) (
   input  logic                        CLK,
   input  logic                        RESET,
   output_buffer_receiver_if.slave     bus
);
   localparam int BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
   localparam int BEAT_W    = OUTPUT_BUS_WIDTH * PIXEL_BITS;
   localparam int ROW_W     = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
   localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_BITS  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
   localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1);

   logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;
   logic [ROW_BITS-1:0]  row_cnt_q, row_cnt_d;
   logic [ROW_W-1:0]     asm_q, asm_d;
   logic [ROW_W-1:0]     row_data_q, row_data_d;
   logic                 row_valid_q, row_valid_d;
   logic [ROW_BITS-1:0]  row_index_q, row_index_d;
   logic                 frame_done_q, frame_done_d;
   logic                 err_short_q, err_short_d;
   logic                 err_overflow_q, err_overflow_d;

   logic row_done;
   logic accept;
   logic slot_free;

   always_comb begin
      beat_cnt_d     = beat_cnt_q;
      row_cnt_d      = row_cnt_q;
      asm_d          = asm_q;
      row_data_d     = row_data_q;
      row_valid_d    = row_valid_q;
      row_index_d    = row_index_q;
      err_short_d    = bus.ERR_CLEAR ? 1'b0 : err_short_q;
      err_overflow_d = bus.ERR_CLEAR ? 1'b0 : err_overflow_q;

      row_done  = bus.BUS_VALID && (beat_cnt_q == LAST_BEAT);
      accept    = row_valid_q && bus.ROW_READY;
      slot_free = !row_valid_q || bus.ROW_READY;

      // asm_d already carries the final beat, so a completed row can be
      // loaded into the slot on the same edge the last beat arrives.
      if (bus.BUS_VALID) begin
         asm_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bus.BUS_DATA;
         beat_cnt_d = row_done ? '0 : beat_cnt_q + BEAT_BITS'(1);
      end else if (beat_cnt_q != '0) begin
         // Burst broke off mid-row: the partial row is abandoned.
         beat_cnt_d  = '0;
         err_short_d = 1'b1;
      end

      if (row_done) begin
         row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + ROW_BITS'(1);
         if (slot_free) begin
            row_data_d  = asm_d;
            row_index_d = row_cnt_q;
            row_valid_d = 1'b1;
         end else begin
            err_overflow_d = 1'b1;
         end
      end else if (accept) begin
         row_valid_d = 1'b0;
      end

      frame_done_d = accept && (row_index_q == LAST_ROW);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         beat_cnt_q     <= '0;
         row_cnt_q      <= '0;
         asm_q          <= '0;
         row_data_q     <= '0;
         row_valid_q    <= 1'b0;
         row_index_q    <= '0;
         frame_done_q   <= 1'b0;
         err_short_q    <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         beat_cnt_q     <= beat_cnt_d;
         row_cnt_q      <= row_cnt_d;
         asm_q          <= asm_d;
         row_data_q     <= row_data_d;
         row_valid_q    <= row_valid_d;
         row_index_q    <= row_index_d;
         frame_done_q   <= frame_done_d;
         err_short_q    <= err_short_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign bus.ROW_DATA     = row_data_q;
   assign bus.ROW_VALID    = row_valid_q;
   assign bus.ROW_INDEX    = row_index_q;
   assign bus.FRAME_DONE   = frame_done_q;
   assign bus.ERR_SHORT    = err_short_q;
   assign bus.ERR_OVERFLOW = err_overflow_q;
endmodule

// File: tb/tb_output_buffer_receiver.sv
module tb_output_buffer_receiver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   output_buffer_receiver_if #(
      .PIXEL_ARRAY_WIDTH(8), .PIXEL_ARRAY_HEIGHT(8),
      .OUTPUT_BUS_WIDTH(2), .PIXEL_BITS(8)
   ) bus_if ();

   output_buffer_receiver #(
      .PIXEL_ARRAY_WIDTH(8), .PIXEL_ARRAY_HEIGHT(8),
      .OUTPUT_BUS_WIDTH(2), .PIXEL_BITS(8)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus_if.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] row_pat(int base);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(base + i);
      return r;
   endfunction

   task automatic send_beat(int base, int k);
      bus_if.BUS_VALID = 1'b1;
      bus_if.BUS_DATA  = {8'(base + 2*k + 1), 8'(base + 2*k)};
      tick();
   endtask

   task automatic send_row(int base);
      for (int k = 0; k < 4; k++) send_beat(base, k);
   endtask

   task automatic do_reset();
      bus_if.BUS_VALID = 1'b0;
      bus_if.BUS_DATA  = '0;
      bus_if.ROW_READY = 1'b0;
      bus_if.ERR_CLEAR = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_DATA !== 64'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus_if.ROW_DATA); end
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL reset_index got=%0d exp=0", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.FRAME_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", bus_if.FRAME_DONE); end
      n_cmp++; if ({bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW} !== 2'b00) begin n_bad++; $display("FAIL reset_errs got=%b exp=00", {bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW}); end
   endtask

   task automatic test_single_row();
      do_reset();
      bus_if.ROW_READY = 1'b1;
      bus_if.BUS_VALID = 1'b1;
      bus_if.BUS_DATA = 16'h0100; tick();
      bus_if.BUS_DATA = 16'h0302; tick();
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", bus_if.ROW_VALID); end
      bus_if.BUS_DATA = 16'h0504; tick();
      bus_if.BUS_DATA = 16'h0706; tick();
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_DATA !== 64'h0706050403020100) begin n_bad++; $display("FAIL single_data got=%h exp=0706050403020100", bus_if.ROW_DATA); end
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL single_index got=%0d exp=0", bus_if.ROW_INDEX); end
      tick();
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop got=%b exp=0", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_DATA !== 64'h0706050403020100) begin n_bad++; $display("FAIL single_data_keep got=%h exp=0706050403020100", bus_if.ROW_DATA); end
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b0) begin n_bad++; $display("FAIL single_no_short got=%b exp=0", bus_if.ERR_SHORT); end
   endtask

   task automatic test_back_to_back();
      int fd_count = 0;
      do_reset();
      bus_if.ROW_READY = 1'b1;
      for (int n = 0; n < 36; n++) begin
         send_beat(8*(n/4), n%4);
         if (bus_if.FRAME_DONE === 1'b1) fd_count++;
         n_cmp++; if (bus_if.FRAME_DONE !== (n == 32)) begin n_bad++; $display("FAIL b2b_frame_done beat=%0d got=%b exp=%b", n, bus_if.FRAME_DONE, (n == 32)); end
         if (n % 4 == 3) begin
            n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", n, bus_if.ROW_VALID); end
            n_cmp++; if (bus_if.ROW_INDEX !== 3'((n/4) % 8)) begin n_bad++; $display("FAIL b2b_index beat=%0d got=%0d exp=%0d", n, bus_if.ROW_INDEX, (n/4) % 8); end
            n_cmp++; if (bus_if.ROW_DATA !== row_pat(8*(n/4))) begin n_bad++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", n, bus_if.ROW_DATA, row_pat(8*(n/4))); end
         end else begin
            n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid beat=%0d got=%b exp=0", n, bus_if.ROW_VALID); end
         end
      end
      bus_if.BUS_VALID = 1'b0;
      tick();
      if (bus_if.FRAME_DONE === 1'b1) fd_count++;
      n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL b2b_frame_done_count got=%0d exp=1", fd_count); end
      n_cmp++; if ({bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW} !== 2'b00) begin n_bad++; $display("FAIL b2b_errs got=%b exp=00", {bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW}); end
   endtask

   task automatic test_short_burst();
      do_reset();
      bus_if.ROW_READY = 1'b1;
      send_beat(0, 0);
      send_beat(0, 1);
      bus_if.BUS_VALID = 1'b0;
      tick();
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b1) begin n_bad++; $display("FAIL short_flag got=%b exp=1", bus_if.ERR_SHORT); end
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL short_no_valid got=%b exp=0", bus_if.ROW_VALID); end
      send_row(16);
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL short_next_valid got=%b exp=1", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL short_next_index got=%0d exp=0", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.ROW_DATA !== row_pat(16)) begin n_bad++; $display("FAIL short_next_data got=%h exp=%h", bus_if.ROW_DATA, row_pat(16)); end
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b1) begin n_bad++; $display("FAIL short_sticky got=%b exp=1", bus_if.ERR_SHORT); end
      bus_if.ERR_CLEAR = 1'b1;
      tick();
      bus_if.ERR_CLEAR = 1'b0;
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b0) begin n_bad++; $display("FAIL short_clear got=%b exp=0", bus_if.ERR_SHORT); end
      // clear coinciding with a new short-burst event: the set wins
      send_beat(0, 0);
      bus_if.BUS_VALID = 1'b0;
      bus_if.ERR_CLEAR = 1'b1;
      tick();
      bus_if.ERR_CLEAR = 1'b0;
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b1) begin n_bad++; $display("FAIL short_set_wins got=%b exp=1", bus_if.ERR_SHORT); end
   endtask

   task automatic test_overflow();
      do_reset();
      bus_if.ROW_READY = 1'b0;
      send_row(0);
      n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL ovf_first_valid got=%b exp=1", bus_if.ROW_VALID); end
      send_row(8);
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ERR_OVERFLOW !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", bus_if.ERR_OVERFLOW); end
      n_cmp++; if (bus_if.ROW_DATA !== row_pat(0)) begin n_bad++; $display("FAIL ovf_hold_data got=%h exp=%h", bus_if.ROW_DATA, row_pat(0)); end
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL ovf_hold_index got=%0d exp=0", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL ovf_hold_valid got=%b exp=1", bus_if.ROW_VALID); end
      bus_if.ROW_READY = 1'b1;
      tick();
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL ovf_accept got=%b exp=0", bus_if.ROW_VALID); end
      send_row(16);
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd2) begin n_bad++; $display("FAIL ovf_next_index got=%0d exp=2", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.ROW_DATA !== row_pat(16)) begin n_bad++; $display("FAIL ovf_next_data got=%h exp=%h", bus_if.ROW_DATA, row_pat(16)); end
      n_cmp++; if (bus_if.ERR_OVERFLOW !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", bus_if.ERR_OVERFLOW); end
      bus_if.ERR_CLEAR = 1'b1;
      tick();
      bus_if.ERR_CLEAR = 1'b0;
      n_cmp++; if (bus_if.ERR_OVERFLOW !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", bus_if.ERR_OVERFLOW); end
   endtask

   task automatic test_accept_same_cycle();
      do_reset();
      bus_if.ROW_READY = 1'b0;
      send_row(0);
      for (int k = 0; k < 3; k++) send_beat(8, k);
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL same_hold_index got=%0d exp=0", bus_if.ROW_INDEX); end
      bus_if.ROW_READY = 1'b1;
      send_beat(8, 3);
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ROW_VALID !== 1'b1) begin n_bad++; $display("FAIL same_valid got=%b exp=1", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd1) begin n_bad++; $display("FAIL same_index got=%0d exp=1", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.ROW_DATA !== row_pat(8)) begin n_bad++; $display("FAIL same_data got=%h exp=%h", bus_if.ROW_DATA, row_pat(8)); end
      n_cmp++; if (bus_if.ERR_OVERFLOW !== 1'b0) begin n_bad++; $display("FAIL same_no_overflow got=%b exp=0", bus_if.ERR_OVERFLOW); end
      tick();
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL same_drain got=%b exp=0", bus_if.ROW_VALID); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus_if.ROW_READY = 1'b0;
      send_row(0);
      send_beat(8, 0);
      send_beat(8, 1);
      bus_if.BUS_VALID = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus_if.ROW_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", bus_if.ROW_VALID); end
      n_cmp++; if (bus_if.ROW_DATA !== 64'h0) begin n_bad++; $display("FAIL mid_data got=%h exp=0", bus_if.ROW_DATA); end
      n_cmp++; if ({bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW} !== 2'b00) begin n_bad++; $display("FAIL mid_errs got=%b exp=00", {bus_if.ERR_SHORT, bus_if.ERR_OVERFLOW}); end
      tick();
      n_cmp++; if (bus_if.ERR_SHORT !== 1'b0) begin n_bad++; $display("FAIL mid_no_short_after got=%b exp=0", bus_if.ERR_SHORT); end
      bus_if.ROW_READY = 1'b1;
      send_row(40);
      bus_if.BUS_VALID = 1'b0;
      n_cmp++; if (bus_if.ROW_INDEX !== 3'd0) begin n_bad++; $display("FAIL mid_fresh_index got=%0d exp=0", bus_if.ROW_INDEX); end
      n_cmp++; if (bus_if.ROW_DATA !== row_pat(40)) begin n_bad++; $display("FAIL mid_fresh_data got=%h exp=%h", bus_if.ROW_DATA, row_pat(40)); end
      tick();
   endtask

   initial begin
      bus_if.BUS_VALID = 1'b0;
      bus_if.BUS_DATA  = '0;
      bus_if.ROW_READY = 1'b0;
      bus_if.ERR_CLEAR = 1'b0;
      test_reset();
      test_single_row();
      test_back_to_back();
      test_short_burst();
      test_overflow();
      test_accept_same_cycle();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
